// File: rtl/stage_decode.sv
// Decode stage: turns the fetch opcode stream into decoded operations, dropping comment bytes.
// Build option DECODE_FOLD_EN: fold runs of + - > < into one operation with a repeat count.
module stage_decode #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned C_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [D_WIDTH-1:0] opcode,
    input  logic               drdy,
    output logic               ack,
    output logic               op_valid,
    input  logic               op_ack,
    output logic [3:0]         op_kind,
    output logic [C_WIDTH-1:0] op_count
);
    typedef enum logic [3:0] {
        K_INC   = 4'd0,
        K_DEC   = 4'd1,
        K_RIGHT = 4'd2,
        K_LEFT  = 4'd3,
        K_OUT   = 4'd4,
        K_IN    = 4'd5,
        K_JZ    = 4'd6,
        K_JNZ   = 4'd7,
        K_HALT  = 4'd8
    } op_kind_e;

    localparam logic [C_WIDTH-1:0] CNT_ONE = C_WIDTH'(1);
`ifdef DECODE_FOLD_EN
    localparam logic [C_WIDTH-1:0] CNT_MAX = {C_WIDTH{1'b1}};
`endif

    logic               op_valid_q, op_valid_d;
    op_kind_e           op_kind_q,  op_kind_d;
    logic [C_WIDTH-1:0] op_count_q, op_count_d;
    logic               blank_q;
    logic               halted_q,   halted_d;
    logic               ack_raw;
    logic               in_instr, in_fold, avail, out_free, flush, acc_busy;
    op_kind_e           in_kind;
`ifdef DECODE_FOLD_EN
    logic               acc_valid_q, acc_valid_d;
    op_kind_e           acc_kind_q,  acc_kind_d;
    logic [C_WIDTH-1:0] acc_count_q, acc_count_d;
`endif

    // Opcode byte classification; anything unlisted is a comment.
    always_comb begin
        in_instr = 1'b1;
        in_kind  = K_INC;
        case (opcode)
            D_WIDTH'(8'h2B): in_kind = K_INC;
            D_WIDTH'(8'h2D): in_kind = K_DEC;
            D_WIDTH'(8'h3E): in_kind = K_RIGHT;
            D_WIDTH'(8'h3C): in_kind = K_LEFT;
            D_WIDTH'(8'h2E): in_kind = K_OUT;
            D_WIDTH'(8'h2C): in_kind = K_IN;
            D_WIDTH'(8'h5B): in_kind = K_JZ;
            D_WIDTH'(8'h5D): in_kind = K_JNZ;
            D_WIDTH'(8'h00): in_kind = K_HALT;
            default:         in_instr = 1'b0;
        endcase
    end

    // The byte right after an ack is a stale repeat from fetch and must be ignored.
    assign avail    = drdy && !blank_q && !halted_q;
    assign out_free = !op_valid_q || op_ack;

`ifdef DECODE_FOLD_EN
    assign in_fold  = in_instr && (in_kind <= K_LEFT);
    assign acc_busy = acc_valid_q;
    assign flush    = acc_valid_q && ((acc_count_q == CNT_MAX) ||
                      (avail && in_instr && !(in_fold && (in_kind == acc_kind_q))));
`else
    assign in_fold  = 1'b0;
    assign acc_busy = 1'b0;
    assign flush    = 1'b0;
`endif

    // Priority: flush accumulator, drop comment, fold, then direct issue.
    always_comb begin
        op_valid_d = op_valid_q && !op_ack;
        op_kind_d  = op_kind_q;
        op_count_d = op_count_q;
        halted_d   = halted_q;
        ack_raw    = 1'b0;
`ifdef DECODE_FOLD_EN
        acc_valid_d = acc_valid_q;
        acc_kind_d  = acc_kind_q;
        acc_count_d = acc_count_q;
`endif
        if (flush) begin
`ifdef DECODE_FOLD_EN
            if (out_free) begin
                op_valid_d  = 1'b1;
                op_kind_d   = acc_kind_q;
                op_count_d  = acc_count_q;
                acc_valid_d = 1'b0;
            end
`endif
        end else if (avail && !in_instr) begin
            ack_raw = 1'b1;
        end else if (avail && in_fold) begin
`ifdef DECODE_FOLD_EN
            ack_raw = 1'b1;
            if (acc_valid_q) begin
                acc_count_d = acc_count_q + CNT_ONE;
            end else begin
                acc_valid_d = 1'b1;
                acc_kind_d  = in_kind;
                acc_count_d = CNT_ONE;
            end
`endif
        end else if (avail && !acc_busy && out_free) begin
            ack_raw    = 1'b1;
            op_valid_d = 1'b1;
            op_kind_d  = in_kind;
            op_count_d = CNT_ONE;
            if (in_kind == K_HALT) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_valid_q <= 1'b0;
            op_kind_q  <= K_INC;
            op_count_q <= '0;
            blank_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            op_valid_q <= op_valid_d;
            op_kind_q  <= op_kind_d;
            op_count_q <= op_count_d;
            blank_q    <= ack_raw;
            halted_q   <= halted_d;
        end
    end

`ifdef DECODE_FOLD_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_valid_q <= 1'b0;
            acc_kind_q  <= K_INC;
            acc_count_q <= '0;
        end else begin
            acc_valid_q <= acc_valid_d;
            acc_kind_q  <= acc_kind_d;
            acc_count_q <= acc_count_d;
        end
    end
`endif

    assign ack      = ack_raw && reset;
    assign op_valid = op_valid_q;
    assign op_kind  = op_kind_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: decode table, directed corner sequences, and random streams
// checked against a run-length model of the decoded program.
module tb_stage_decode;
    localparam int unsigned D_W = 8;
    localparam int unsigned C_W = 8;
    localparam int MAXC = 255;
`ifdef DECODE_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    typedef struct {
        logic [3:0] kind;
        logic [7:0] cnt;
    } op_t;

    typedef struct {
        logic [7:0] b;
        bit         has_op;
        logic [3:0] kind;
        int         consumed;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [D_W-1:0] opcode = '0;
    logic           drdy = 1'b0;
    logic           ack;
    logic           op_valid;
    logic           op_ack = 1'b0;
    logic [3:0]     op_kind;
    logic [C_W-1:0] op_count;

    stage_decode #(.D_WIDTH(D_W), .C_WIDTH(C_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .drdy(drdy), .ack(ack),
        .op_valid(op_valid), .op_ack(op_ack), .op_kind(op_kind), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] src[$];
    op_t        exp_q[$];
    op_t        got_q[$];
    bit         ack_log[$];
    int         idx, exp_consumed, ack_prob, gap_prob;
    bit         stale, have_prev, prev_valid, prev_take;
    logic [7:0] last_b;
    logic [3:0] prev_kind;
    logic [7:0] prev_cnt;
    vec_t       tbl[12];

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int kind_of(input logic [7:0] b);
        case (b)
            8'h2B: return 0;
            8'h2D: return 1;
            8'h3E: return 2;
            8'h3C: return 3;
            8'h2E: return 4;
            8'h2C: return 5;
            8'h5B: return 6;
            8'h5D: return 7;
            8'h00: return 8;
            default: return -1;
        endcase
    endfunction

    function automatic void push_exp(input int k, input int n);
        op_t o;
        o.kind = 4'(k);
        o.cnt  = 8'(n);
        exp_q.push_back(o);
    endfunction

    function automatic void add_str(input string s);
        for (int i = 0; i < s.len(); i++) src.push_back(8'(s[i]));
    endfunction

    // Expected program: drop comments, run-length encode foldables capped at MAXC, stop at HALT.
    function automatic void model();
        int run_k = -1;
        int run_n = 0;
        exp_q.delete();
        exp_consumed = src.size();
        for (int i = 0; i < src.size(); i++) begin
            int k = kind_of(src[i]);
            if (k < 0) continue;
            if (FOLD && k <= 3) begin
                if (k == run_k && run_n < MAXC) run_n++;
                else begin
                    if (run_k >= 0) push_exp(run_k, run_n);
                    run_k = k;
                    run_n = 1;
                end
            end else begin
                if (run_k >= 0) push_exp(run_k, run_n);
                run_k = -1;
                push_exp(k, 1);
                if (k == 8) begin
                    exp_consumed = i + 1;
                    break;
                end
            end
        end
    endfunction

    function automatic logic [7:0] rand_byte();
        int r = int'($urandom_range(0, 39));
        case (r)
            0, 1, 2:    return 8'h2B;
            3, 4, 5:    return 8'h2D;
            6, 7, 8:    return 8'h3E;
            9, 10, 11:  return 8'h3C;
            12, 13:     return 8'h2E;
            14, 15:     return 8'h2C;
            16, 17:     return 8'h5B;
            18, 19:     return 8'h5D;
            20:         return 8'h00;
            default:    return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One clock: sample at negedge, drive fetch and execute models, sample ack just before posedge.
    task automatic cycle();
        bit cur_real, take, a;
        if (have_prev && prev_valid && !prev_take) begin
            chk("hold_valid", int'(op_valid), 1);
            chk("hold_kind", int'(op_kind), int'(prev_kind));
            chk("hold_count", int'(op_count), int'(prev_cnt));
        end
        op_ack = (int'($urandom_range(0, 99)) < ack_prob);
        take = op_valid && op_ack;
        if (stale) begin
            drdy = 1'b1;
            opcode = last_b;
            cur_real = 1'b0;
        end else if (idx < src.size() && int'($urandom_range(0, 99)) >= gap_prob) begin
            drdy = 1'b1;
            opcode = src[idx];
            cur_real = 1'b1;
        end else begin
            drdy = 1'b0;
            opcode = 8'($urandom_range(0, 255));
            cur_real = 1'b0;
        end
        #4;
        a = ack;
        ack_log.push_back(a);
        if (!cur_real) chk("ack_stale_or_idle", int'(a), 0);
        if (take) begin
            op_t o;
            o.kind = op_kind;
            o.cnt  = op_count;
            got_q.push_back(o);
        end
        have_prev  = 1'b1;
        prev_valid = op_valid;
        prev_take  = take;
        prev_kind  = op_kind;
        prev_cnt   = op_count;
        if (a && cur_real) begin
            last_b = src[idx];
            idx++;
            stale = 1'b1;
        end else begin
            stale = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drdy = 1'b1;
        opcode = 8'h2E;
        op_ack = 1'b0;
        #1;
        chk("rst_ack", int'(ack), 0);
        chk("rst_valid", int'(op_valid), 0);
        chk("rst_kind", int'(op_kind), 0);
        chk("rst_count", int'(op_count), 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_ack", int'(ack), 0);
        chk("rst_hold_valid", int'(op_valid), 0);
        reset = 1'b1;
        idx = 0;
        stale = 1'b0;
        have_prev = 1'b0;
        got_q.delete();
        ack_log.delete();
    endtask

    task automatic run_stream(input string name);
        int cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 4000) begin
            cycle();
            cyc++;
        end
        chk($sformatf("%s_timeout", name), (got_q.size() < exp_q.size()) ? 1 : 0, 0);
        repeat (6) cycle();
        chk($sformatf("%s_nops", name), got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_op%0d_kind", name, i), int'(got_q[i].kind), int'(exp_q[i].kind));
            chk($sformatf("%s_op%0d_count", name, i), int'(got_q[i].cnt), int'(exp_q[i].cnt));
        end
        chk($sformatf("%s_consumed", name), idx, exp_consumed);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'h2B, 1'b1, 4'd0, 2};
        tbl[1]  = '{8'h2D, 1'b1, 4'd1, 2};
        tbl[2]  = '{8'h3E, 1'b1, 4'd2, 2};
        tbl[3]  = '{8'h3C, 1'b1, 4'd3, 2};
        tbl[4]  = '{8'h2E, 1'b1, 4'd4, 2};
        tbl[5]  = '{8'h2C, 1'b1, 4'd5, 2};
        tbl[6]  = '{8'h5B, 1'b1, 4'd6, 2};
        tbl[7]  = '{8'h5D, 1'b1, 4'd7, 2};
        tbl[8]  = '{8'h00, 1'b0, 4'd8, 1};
        tbl[9]  = '{8'h41, 1'b0, 4'd0, 2};
        tbl[10] = '{8'hFF, 1'b0, 4'd0, 2};
        tbl[11] = '{8'h2A, 1'b0, 4'd0, 2};
        @(negedge clk);

        // single-byte decode table, each followed by HALT
        for (int i = 0; i < 12; i++) begin
            do_reset();
            src.delete();
            src.push_back(tbl[i].b);
            src.push_back(8'h00);
            exp_q.delete();
            if (tbl[i].has_op) push_exp(int'(tbl[i].kind), 1);
            push_exp(8, 1);
            exp_consumed = tbl[i].consumed;
            ack_prob = 100;
            gap_prob = 0;
            run_stream($sformatf("tbl%0d", i));
        end

        // first byte after reset is taken at once; second waits for the output
        do_reset();
        src.delete();
        add_str("..");
        src.push_back(8'h00);
        ack_prob = 0;
        gap_prob = 0;
        repeat (4) cycle();
        ack_prob = 100;
        cycle();
        chk("first_ack_c0", int'(ack_log[0]), 1);
        chk("first_ack_c1", int'(ack_log[1]), 0);
        chk("first_ack_c2", int'(ack_log[2]), 0);
        chk("first_ack_c3", int'(ack_log[3]), 0);
        chk("first_ack_c4", int'(ack_log[4]), 1);
        exp_q.delete();
        push_exp(4, 1);
        push_exp(4, 1);
        push_exp(8, 1);
        exp_consumed = 3;
        run_stream("first_ack");

        // folding with trailing bytes after HALT that must never be acked
        do_reset();
        src.delete();
        add_str("+++.");
        src.push_back(8'h00);
        add_str("++");
        exp_q.delete();
        if (FOLD) push_exp(0, 3);
        else repeat (3) push_exp(0, 1);
        push_exp(4, 1);
        push_exp(8, 1);
        exp_consumed = 5;
        ack_prob = 100;
        gap_prob = 0;
        run_stream("fold");

        // comments inside a run, drdy high across every stale cycle
        do_reset();
        src.delete();
        add_str("+a+]");
        src.push_back(8'h00);
        exp_q.delete();
        if (FOLD) push_exp(0, 2);
        else repeat (2) push_exp(0, 1);
        push_exp(7, 1);
        push_exp(8, 1);
        exp_consumed = 5;
        run_stream("comments");

        // saturation of the repeat count
        do_reset();
        src.delete();
        repeat (300) src.push_back(8'h2B);
        src.push_back(8'h00);
        exp_q.delete();
        if (FOLD) begin
            push_exp(0, 255);
            push_exp(0, 45);
        end else begin
            repeat (300) push_exp(0, 1);
        end
        push_exp(8, 1);
        exp_consumed = 301;
        run_stream("saturate");

        // backpressure holds the output and stalls intake, then async reset mid-run
        do_reset();
        src.delete();
        add_str("><.");
        ack_prob = 0;
        gap_prob = 0;
        repeat (12) cycle();
        chk("bp_valid", int'(op_valid), 1);
        chk("bp_kind", int'(op_kind), 2);
        chk("bp_count", int'(op_count), 1);
        chk("bp_consumed", idx, FOLD ? 2 : 1);
        for (int i = 6; i < 12; i++) chk($sformatf("bp_ack_c%0d", i), int'(ack_log[i]), 0);
        drdy = 1'b1;
        opcode = 8'h2E;
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", int'(op_valid), 0);
        chk("async_rst_kind", int'(op_kind), 0);
        chk("async_rst_count", int'(op_count), 0);
        chk("async_rst_ack", int'(ack), 0);
        @(negedge clk);

        // random programs against the run-length model
        for (int t = 0; t < 40; t++) begin
            int len;
            do_reset();
            src.delete();
            len = int'($urandom_range(1, 40));
            for (int j = 0; j < len; j++) begin
                logic [7:0] b;
                int k, n;
                b = rand_byte();
                k = kind_of(b);
                n = (k >= 0 && k <= 3) ? int'($urandom_range(1, 6)) : 1;
                repeat (n) src.push_back(b);
            end
            if (t % 8 == 7) repeat (260) src.push_back(8'h3C);
            src.push_back(8'h00);
            ack_prob = int'($urandom_range(20, 100));
            gap_prob = int'($urandom_range(0, 50));
            model();
            run_stream($sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
